// File: rtl/hex_word_assembler.sv
// hex_word_assembler: assembles ASCII hex digits from a UART byte stream into words.
module hex_word_assembler #(
  parameter int MAX_DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [7:0]              rx_data,
  input  logic                    rx_valid,
  output logic [4*MAX_DIGITS-1:0] word_out,
  output logic                    word_valid,
  output logic                    err,
  output logic [1:0]              err_code,
  output logic                    busy
);
  localparam int W  = 4 * MAX_DIGITS;
  localparam int CW = $clog2(MAX_DIGITS + 1);
  typedef enum logic [1:0] {IDLE, ACCUM, DISCARD} state_t;
  state_t         state_q;
  logic [W-1:0]   acc_q;
  logic [CW-1:0]  cnt_q;
  logic [W-1:0]   word_q;
  logic           wv_q;
  logic           err_q;
  logic [1:0]     code_q;
  logic           is_dig;
  logic           is_af;
  logic           is_hex;
  logic           is_term;
  logic           is_space;
  logic           is_esc;
  logic [3:0]     nib;
  logic [7:0]     lower;
  always_comb begin
    lower    = rx_data | 8'h20;
    is_dig   = rx_data >= 8'h30 && rx_data <= 8'h39;
    is_af    = lower >= 8'h61 && lower <= 8'h66;
    is_hex   = is_dig || is_af;
    is_term  = rx_data == 8'h0D || rx_data == 8'h0A;
    is_space = rx_data == 8'h20;
    is_esc   = rx_data == 8'h1B;
    // letters A-F/a-f carry 1..6 in their low nibble
    nib      = is_dig ? rx_data[3:0] : rx_data[3:0] + 4'd9;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      word_q  <= '0;
      wv_q    <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= 2'b00;
    end else begin
      wv_q  <= 1'b0;
      err_q <= 1'b0;
      if (rx_valid) begin
        if (is_esc) begin
          state_q <= IDLE;
          acc_q   <= '0;
          cnt_q   <= '0;
        end else begin
          case (state_q)
            IDLE: begin
              if (is_hex) begin
                acc_q   <= W'(nib);
                cnt_q   <= CW'(1);
                state_q <= ACCUM;
              end else if (!is_term && !is_space) begin
                err_q   <= 1'b1;
                code_q  <= 2'b01;
                state_q <= DISCARD;
              end
            end
            ACCUM: begin
              if (is_hex && cnt_q != CW'(MAX_DIGITS)) begin
                acc_q <= (acc_q << 4) | W'(nib);
                cnt_q <= cnt_q + CW'(1);
              end else if (is_term) begin
                word_q  <= acc_q;
                wv_q    <= 1'b1;
                cnt_q   <= '0;
                state_q <= IDLE;
              end else begin
                err_q   <= 1'b1;
                code_q  <= is_hex ? 2'b10 : 2'b01;
                cnt_q   <= '0;
                state_q <= DISCARD;
              end
            end
            default: if (is_term) state_q <= IDLE;
          endcase
        end
      end
    end
  end
  assign word_out   = word_q;
  assign word_valid = wv_q;
  assign err        = err_q;
  assign err_code   = code_q;
  assign busy       = state_q != IDLE;
endmodule

// File: tb/tb_hex_word_assembler.sv
// tb_hex_word_assembler: directed vector table, reset/ESC sequences and a randomized model check.
module tb_hex_word_assembler;
  localparam int MAXD = 4;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [15:0] word_out;
  logic        word_valid;
  logic        err;
  logic [1:0]  err_code;
  logic        busy;
  int          errors = 0;
  int          checks = 0;

  hex_word_assembler #(.MAX_DIGITS(MAXD)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .word_out(word_out), .word_valid(word_valid), .err(err),
    .err_code(err_code), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  d;
    logic        wv;
    logic        er;
    logic [1:0]  code;
    logic [15:0] word;
    logic        bsy;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input logic wv, input logic er, input logic [1:0] code,
                         input logic [15:0] word, input logic bsy);
    chk("word_valid", 32'(word_valid), 32'(wv));
    chk("err", 32'(err), 32'(er));
    chk("err_code", 32'(err_code), 32'(code));
    chk("word_out", 32'(word_out), 32'(word));
    chk("busy", 32'(busy), 32'(bsy));
  endtask

  task automatic step(input logic [7:0] d, input logic v);
    @(negedge clk);
    rx_data  = d;
    rx_valid = v;
    @(posedge clk);
    #1;
  endtask

  // Reference model: digits kept as a queue, word value folded arithmetically.
  int         m_mode;
  int         m_digits[$];
  logic [15:0] m_word;
  logic [1:0]  m_code;
  logic        m_wv;
  logic        m_err;

  function automatic int hex_val(input logic [7:0] c);
    if (c >= "0" && c <= "9") return int'(c) - int'("0");
    if (c >= "a" && c <= "f") return int'(c) - int'("a") + 10;
    if (c >= "A" && c <= "F") return int'(c) - int'("A") + 10;
    return -1;
  endfunction

  task automatic model(input logic [7:0] c, input logic v);
    int  h;
    int  val;
    bit  term;
    m_wv  = 0;
    m_err = 0;
    if (!v) return;
    h    = hex_val(c);
    term = (c == 8'h0D) || (c == 8'h0A);
    if (c == 8'h1B) begin
      m_mode = 0;
      m_digits.delete();
    end else if (m_mode == 0) begin
      if (h >= 0) begin
        m_digits = '{h};
        m_mode = 1;
      end else if (!term && c != 8'h20) begin
        m_err = 1; m_code = 2'b01; m_mode = 2;
      end
    end else if (m_mode == 1) begin
      if (h >= 0 && m_digits.size() < MAXD) m_digits.push_back(h);
      else if (h >= 0) begin
        m_err = 1; m_code = 2'b10; m_mode = 2;
      end else if (term) begin
        val = 0;
        foreach (m_digits[i]) val = val * 16 + m_digits[i];
        m_word = 16'(val);
        m_wv = 1; m_mode = 0;
      end else begin
        m_err = 1; m_code = 2'b01; m_mode = 2;
      end
    end else if (term) m_mode = 0;
  endtask

  vec_t vt[$];
  string hexchars = "0123456789abcdefABCDEF";

  initial begin
    vt = '{
      '{"1",   0,0,2'd0,16'h0000,1}, '{"A",  0,0,2'd0,16'h0000,1},
      '{"2",   0,0,2'd0,16'h0000,1}, '{"F",  0,0,2'd0,16'h0000,1},
      '{8'h0D, 1,0,2'd0,16'h1A2F,0},
      '{"a",   0,0,2'd0,16'h1A2F,1}, '{"b",  0,0,2'd0,16'h1A2F,1},
      '{8'h0A, 1,0,2'd0,16'h00AB,0},
      '{8'h0D, 0,0,2'd0,16'h00AB,0}, '{8'h0A,0,0,2'd0,16'h00AB,0},
      '{"1",   0,0,2'd0,16'h00AB,1}, '{"2",  0,0,2'd0,16'h00AB,1},
      '{"3",   0,0,2'd0,16'h00AB,1}, '{"4",  0,0,2'd0,16'h00AB,1},
      '{"5",   0,1,2'd2,16'h00AB,1}, '{8'h0D,0,0,2'd2,16'h00AB,0},
      '{"7",   0,0,2'd2,16'h00AB,1}, '{8'h0D,1,0,2'd2,16'h0007,0},
      '{"1",   0,0,2'd2,16'h0007,1}, '{"G",  0,1,2'd1,16'h0007,1},
      '{8'h0D, 0,0,2'd1,16'h0007,0},
      '{" ",   0,0,2'd1,16'h0007,0}, '{"x",  0,1,2'd1,16'h0007,1},
      '{"Z",   0,0,2'd1,16'h0007,1}, '{8'h1B,0,0,2'd1,16'h0007,0},
      '{"5",   0,0,2'd1,16'h0007,1}, '{" ",  0,1,2'd1,16'h0007,1},
      '{"3",   0,0,2'd1,16'h0007,1}, '{8'h0A,0,0,2'd1,16'h0007,0}
    };
    #1;
    chk_all(0, 0, 2'd0, 16'h0000, 0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    foreach (vt[i]) begin
      step(vt[i].d, 1'b1);
      chk_all(vt[i].wv, vt[i].er, vt[i].code, vt[i].word, vt[i].bsy);
    end

    // Reset in the middle of a word discards it.
    step("1", 1'b1);
    step("2", 1'b1);
    chk("busy_before_rst", 32'(busy), 32'd1);
    @(negedge clk);
    rx_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_all(0, 0, 2'd0, 16'h0000, 0);
    repeat (3) begin
      @(posedge clk);
      #1;
      chk_all(0, 0, 2'd0, 16'h0000, 0);
    end
    @(negedge clk) rst_n = 1'b1;
    step("3", 1'b1);
    chk_all(0, 0, 2'd0, 16'h0000, 1);
    step(8'h0D, 1'b1);
    chk_all(1, 0, 2'd0, 16'h0003, 0);

    // ESC mid-word with random idle gaps.
    begin
      logic [7:0] seq [4];
      seq = '{"9", 8'h1B, "4", 8'h0D};
      for (int k = 0; k < 4; k++) begin
        int g;
        g = $urandom_range(0, 5);
        for (int j = 0; j < g; j++) begin
          step(8'h1B, 1'b0);
          chk("gap_err", 32'(err), 32'd0);
        end
        step(seq[k], 1'b1);
        chk("esc_err", 32'(err), 32'd0);
      end
      chk("esc_word", 32'(word_out), 32'h0004);
      chk("esc_wv", 32'(word_valid), 32'd1);
    end

    m_mode = 0;
    m_digits.delete();
    m_word = 16'h0004;
    m_code = 2'b00;
    for (int n = 0; n < 600; n++) begin
      logic [7:0] c;
      logic       v;
      int         r;
      r = $urandom_range(0, 19);
      c = (r < 9)  ? hexchars[$urandom_range(0, 21)] :
          (r < 12) ? 8'h0D :
          (r < 14) ? 8'h0A :
          (r < 16) ? 8'h20 :
          (r < 17) ? 8'h1B : 8'($urandom_range(0, 255));
      v = $urandom_range(0, 3) != 0;
      model(c, v);
      step(c, v);
      chk_all(m_wv, m_err, m_code, m_word, m_mode != 0);
      chk("excl", 32'(word_valid & err), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
